// File: rtl/cart_mem_responder_if.sv
// SDRAM-side single-beat req/ack bus used by cart_mem_responder.
// master: the responder (drives the request); slave: the SDRAM arbiter port.
interface cart_mem_responder_if #(
  parameter int unsigned ADDR_W = 25
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/cart_mem_responder.sv
// Memory-side responder for the 2600 cartridge mapper bus.
// Turns mapper ROM fetches and cart-RAM read/write strobes into single-beat
// req/ack SDRAM transactions and returns registered read data.
// Optional: define CART_MEM_LASTHIT_EN to retire repeated ROM fetches of the
// last completed address from a one-entry tag without touching SDRAM.
module cart_mem_responder #(
  parameter int unsigned       ADDR_W   = 25,
  parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(25'h0000000),
  parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(25'h0100000)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [18:0]                 rom_a,
  input  logic                        rom_read,
  output logic [7:0]                  rom_do,
  input  logic [17:0]                 cartram_addr,
  input  logic                        cartram_rd,
  input  logic                        cartram_wr,
  input  logic [7:0]                  cartram_wrdata,
  output logic [7:0]                  cartram_data,
  output logic                        busy,
  cart_mem_responder_if.master        mem
);

  localparam int unsigned ROM_AW = 19;
  localparam int unsigned RAM_AW = 18;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ROM_WAIT,
    RRD_WAIT,
    RWR_WAIT
  } state_t;

  state_t              state_q, state_d;

  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rom_do_q, rom_do_d;
  logic [DATA_W-1:0]   ram_do_q, ram_do_d;
  logic                busy_q, busy_d;

  // previous strobe/address samples for edge and change detection
  logic                rom_read_q;
  logic [ROM_AW-1:0]   rom_a_q;
  logic                ram_rd_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic                ram_wr_q;

  // pending flags and their captures
  logic                rom_pend_q, rom_pend_d;
  logic [ROM_AW-1:0]   rom_cap_q, rom_cap_d;
  logic                rd_pend_q, rd_pend_d;
  logic [RAM_AW-1:0]   rd_cap_q, rd_cap_d;
  logic                wr_pend_q, wr_pend_d;
  logic [RAM_AW-1:0]   wr_cap_q, wr_cap_d;
  logic [DATA_W-1:0]   wr_dat_q, wr_dat_d;

  // address of the in-flight read, compared against the live address on ack
  logic [ROM_AW-1:0]   gnt_addr_q, gnt_addr_d;

  logic                rom_det, rd_det, wr_det;
  logic                rom_avail, rd_avail, wr_avail;
  logic [ROM_AW-1:0]   rom_sel;
  logic [RAM_AW-1:0]   rd_sel, wr_sel;
  logic [DATA_W-1:0]   wr_sel_dat;
  logic                rom_hit;

`ifdef CART_MEM_LASTHIT_EN
  logic                tag_vld_q, tag_vld_d;
  logic [ROM_AW-1:0]   tag_addr_q, tag_addr_d;
`endif

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign rom_do        = rom_do_q;
  assign cartram_data  = ram_do_q;
  assign busy          = busy_q;

  // request detection; a pending request or a fresh detection may be granted
  always_comb begin
    rom_det    = rom_read && (!rom_read_q || (rom_a != rom_a_q));
    rd_det     = cartram_rd && (!ram_rd_q || (cartram_addr != ram_addr_q));
    wr_det     = cartram_wr && !ram_wr_q;
    rom_avail  = rom_pend_q || rom_det;
    rd_avail   = rd_pend_q || rd_det;
    wr_avail   = wr_pend_q || wr_det;
    rom_sel    = rom_pend_q ? rom_cap_q : rom_a;
    rd_sel     = rd_pend_q ? rd_cap_q : cartram_addr;
    wr_sel     = wr_pend_q ? wr_cap_q : cartram_addr;
    wr_sel_dat = wr_pend_q ? wr_dat_q : cartram_wrdata;
`ifdef CART_MEM_LASTHIT_EN
    rom_hit    = tag_vld_q && (rom_sel == tag_addr_q);
`else
    rom_hit    = 1'b0;
`endif
  end

  // next-state, bus and pending-flag logic
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rom_do_d   = rom_do_q;
    ram_do_d   = ram_do_q;
    rom_pend_d = rom_pend_q;
    rom_cap_d  = rom_cap_q;
    rd_pend_d  = rd_pend_q;
    rd_cap_d   = rd_cap_q;
    wr_pend_d  = wr_pend_q;
    wr_cap_d   = wr_cap_q;
    wr_dat_d   = wr_dat_q;
    gnt_addr_d = gnt_addr_q;
`ifdef CART_MEM_LASTHIT_EN
    tag_vld_d  = tag_vld_q;
    tag_addr_d = tag_addr_q;
`endif

    if (rom_det) begin
      rom_pend_d = 1'b1;
      rom_cap_d  = rom_a;
    end
    if (rd_det) begin
      rd_pend_d = 1'b1;
      rd_cap_d  = cartram_addr;
    end
    if (wr_det) begin
      wr_pend_d = 1'b1;
      wr_cap_d  = cartram_addr;
      wr_dat_d  = cartram_wrdata;
    end

    case (state_q)
      IDLE: begin
        // a same-kind detection alongside a granted pending entry stays queued
        if (wr_avail) begin
          state_d    = RWR_WAIT;
          req_d      = 1'b1;
          we_d       = 1'b1;
          addr_d     = RAM_BASE + ADDR_W'(wr_sel);
          wdata_d    = wr_sel_dat;
          gnt_addr_d = ROM_AW'(wr_sel);
          wr_pend_d  = wr_pend_q && wr_det;
        end else if (rd_avail) begin
          state_d    = RRD_WAIT;
          req_d      = 1'b1;
          we_d       = 1'b0;
          addr_d     = RAM_BASE + ADDR_W'(rd_sel);
          gnt_addr_d = ROM_AW'(rd_sel);
          rd_pend_d  = rd_pend_q && rd_det;
        end else if (rom_avail) begin
          rom_pend_d = rom_pend_q && rom_det;
          if (!rom_hit) begin
            state_d    = ROM_WAIT;
            req_d      = 1'b1;
            we_d       = 1'b0;
            addr_d     = ROM_BASE + ADDR_W'(rom_sel);
            gnt_addr_d = rom_sel;
          end
        end
      end

      ROM_WAIT: begin
        if (mem.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (gnt_addr_q == rom_a) begin
            rom_do_d = mem.mem_rdata;
`ifdef CART_MEM_LASTHIT_EN
            tag_vld_d  = 1'b1;
            tag_addr_d = gnt_addr_q;
`endif
          end else begin
            // stale: the mapper moved on, refetch at the current address
            rom_pend_d = 1'b1;
            rom_cap_d  = rom_a;
          end
        end
      end

      RRD_WAIT: begin
        if (mem.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (gnt_addr_q == {1'b0, cartram_addr}) begin
            ram_do_d = mem.mem_rdata;
          end else begin
            rd_pend_d = 1'b1;
            rd_cap_d  = cartram_addr;
          end
        end
      end

      RWR_WAIT: begin
        if (mem.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rom_do_q   <= '0;
      ram_do_q   <= '0;
      busy_q     <= 1'b0;
      rom_read_q <= 1'b0;
      rom_a_q    <= '0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      rom_pend_q <= 1'b0;
      rom_cap_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_cap_q   <= '0;
      wr_pend_q  <= 1'b0;
      wr_cap_q   <= '0;
      wr_dat_q   <= '0;
      gnt_addr_q <= '0;
`ifdef CART_MEM_LASTHIT_EN
      tag_vld_q  <= 1'b0;
      tag_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rom_do_q   <= rom_do_d;
      ram_do_q   <= ram_do_d;
      busy_q     <= busy_d;
      rom_read_q <= rom_read;
      rom_a_q    <= rom_a;
      ram_rd_q   <= cartram_rd;
      ram_addr_q <= cartram_addr;
      ram_wr_q   <= cartram_wr;
      rom_pend_q <= rom_pend_d;
      rom_cap_q  <= rom_cap_d;
      rd_pend_q  <= rd_pend_d;
      rd_cap_q   <= rd_cap_d;
      wr_pend_q  <= wr_pend_d;
      wr_cap_q   <= wr_cap_d;
      wr_dat_q   <= wr_dat_d;
      gnt_addr_q <= gnt_addr_d;
`ifdef CART_MEM_LASTHIT_EN
      tag_vld_q  <= tag_vld_d;
      tag_addr_q <= tag_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cart_mem_responder.sv
// Self-checking bench for cart_mem_responder: SDRAM model with fixed ack
// latency, request scoreboard, and directed mapper-side scenarios.
module tb_cart_mem_responder;

  localparam logic [24:0] ROM_BASE = 25'h0000000;
  localparam logic [24:0] RAM_BASE = 25'h0100000;

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [18:0] rom_a;
  logic        rom_read;
  logic [7:0]  rom_do;
  logic [17:0] cartram_addr;
  logic        cartram_rd;
  logic        cartram_wr;
  logic [7:0]  cartram_wrdata;
  logic [7:0]  cartram_data;
  logic        busy;

  cart_mem_responder_if #(.ADDR_W(25)) mem ();

  cart_mem_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rom_a          (rom_a),
    .rom_read       (rom_read),
    .rom_do         (rom_do),
    .cartram_addr   (cartram_addr),
    .cartram_rd     (cartram_rd),
    .cartram_wr     (cartram_wr),
    .cartram_wrdata (cartram_wrdata),
    .cartram_data   (cartram_data),
    .busy           (busy),
    .mem            (mem)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  req_t exp_q[$];
  logic [7:0] sdram [logic [24:0]];

  int   ack_lat  = 3;
  logic hold_ack = 1'b0;
  int   req_cnt  = 0;
  int   ack_cnt  = 0;
  int   wait_cnt = 0;
  int   gap      = 100;
  logic req_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [24:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (sdram.exists(a)) return sdram[a];
    return lo ^ 8'hC3;
  endfunction

  task automatic push_req(input logic we, input logic [24:0] addr, input logic [7:0] wdata);
    req_t r;
    r.we = we;
    r.addr = addr;
    r.wdata = wdata;
    exp_q.push_back(r);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 4; i++) begin
      @(negedge clk);
      if (!busy && !mem.mem_req) quiet++;
      else quiet = 0;
    end
    check_eq(tag, 32'(quiet >= 4), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = mem.mem_req;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_ack(input string tag);
    int start = ack_cnt;
    for (int i = 0; i < 50 && ack_cnt == start; i++) @(negedge clk);
    check_eq(tag, 32'(ack_cnt != start), 32'd1);
  endtask

  // SDRAM model: scoreboards each new request, acks after ack_lat cycles
  always @(negedge clk) begin
    if (!reset_n) begin
      mem.mem_ack = 1'b0;
      req_prev    = 1'b0;
      wait_cnt    = 0;
    end else begin
      if (mem.mem_req && !req_prev) begin
        req_t e;
        req_cnt++;
        wait_cnt = 0;
        check_eq("req_gap", 32'(gap >= 1), 32'd1);
        check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_we", 32'(mem.mem_we), 32'(e.we));
          check_eq("sb_addr", 32'(mem.mem_addr), 32'(e.addr));
          if (e.we) check_eq("sb_wdata", 32'(mem.mem_wdata), 32'(e.wdata));
        end
      end
      if (mem.mem_req) gap = 0;
      else gap++;
      req_prev = mem.mem_req;
      if (mem.mem_ack) begin
        mem.mem_ack = 1'b0;
      end else if (mem.mem_req && !hold_ack) begin
        if (wait_cnt == ack_lat) begin
          mem.mem_ack = 1'b1;
          ack_cnt++;
          if (mem.mem_we) sdram[mem.mem_addr] = mem.mem_wdata;
          else mem.mem_rdata = mem_rd(mem.mem_addr);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset_n        = 1'b0;
    rom_a          = '0;
    rom_read       = 1'b0;
    cartram_addr   = '0;
    cartram_rd     = 1'b0;
    cartram_wr     = 1'b0;
    cartram_wrdata = '0;
    mem.mem_ack    = 1'b0;
    mem.mem_rdata  = '0;
    sdram[ROM_BASE + 25'h01234] = 8'hA5;
    sdram[ROM_BASE + 25'h00100] = 8'h11;
    sdram[ROM_BASE + 25'h00200] = 8'h22;
    sdram[ROM_BASE + 25'h00300] = 8'h77;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", 32'(mem.mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem.mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem.mem_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rom_do", 32'(rom_do), 32'd0);
    check_eq("rst_cartram_data", 32'(cartram_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // basic ROM fetch with exact latency
    rom_a    = 19'h01234;
    rom_read = 1'b1;
    push_req(1'b0, ROM_BASE + 25'h01234, 8'h00);
    @(negedge clk);
    check_eq("t1_req", 32'(mem.mem_req), 32'd1);
    check_eq("t1_we", 32'(mem.mem_we), 32'd0);
    check_eq("t1_addr", 32'(mem.mem_addr), 32'(ROM_BASE + 25'h01234));
    check_eq("t1_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t1_rom_do_early", 32'(rom_do), 32'd0);
    check_eq("t1_req_held", 32'(mem.mem_req), 32'd1);
    @(negedge clk);
    check_eq("t1_rom_do", 32'(rom_do), 32'hA5);
    check_eq("t1_req_drop", 32'(mem.mem_req), 32'd0);
    check_eq("t1_busy_drop", 32'(busy), 32'd0);

    // re-fetch of the same ROM address after a completed fetch
    rom_read = 1'b0;
    repeat (2) @(negedge clk);
    base = req_cnt;
    rom_read = 1'b1;
`ifdef CART_MEM_LASTHIT_EN
    @(negedge clk);
    check_eq("lh_busy", 32'(busy), 32'd0);
    check_eq("lh_req", 32'(mem.mem_req), 32'd0);
    wait_idle("lh_idle");
    check_eq("lh_req_cnt", 32'(req_cnt - base), 32'd0);
`else
    push_req(1'b0, ROM_BASE + 25'h01234, 8'h00);
    wait_idle("lh_idle");
    check_eq("lh_req_cnt", 32'(req_cnt - base), 32'd1);
`endif
    check_eq("lh_rom_do", 32'(rom_do), 32'hA5);
    rom_read = 1'b0;
    @(negedge clk);

    // held write strobe issues exactly one write
    base = req_cnt;
    cartram_addr   = 18'h00010;
    cartram_wrdata = 8'h3C;
    cartram_wr     = 1'b1;
    push_req(1'b1, RAM_BASE + 25'h00010, 8'h3C);
    repeat (10) @(negedge clk);
    cartram_wr = 1'b0;
    wait_idle("wr_idle");
    check_eq("wr_req_cnt", 32'(req_cnt - base), 32'd1);

    // priority: write, then cart-RAM read, then ROM read
    base = req_cnt;
    cartram_addr   = 18'h00020;
    cartram_wrdata = 8'h5A;
    rom_a          = 19'h00300;
    cartram_wr     = 1'b1;
    cartram_rd     = 1'b1;
    rom_read       = 1'b1;
    push_req(1'b1, RAM_BASE + 25'h00020, 8'h5A);
    push_req(1'b0, RAM_BASE + 25'h00020, 8'h00);
    push_req(1'b0, ROM_BASE + 25'h00300, 8'h00);
    wait_idle("pri_idle");
    check_eq("pri_req_cnt", 32'(req_cnt - base), 32'd3);
    check_eq("pri_cartram_data", 32'(cartram_data), 32'h5A);
    check_eq("pri_rom_do", 32'(rom_do), 32'h77);
    cartram_wr = 1'b0;
    cartram_rd = 1'b0;
    rom_read   = 1'b0;
    repeat (2) @(negedge clk);

    // stale ROM data is dropped and the fetch reissued
    base = req_cnt;
    rom_a    = 19'h00100;
    rom_read = 1'b1;
    push_req(1'b0, ROM_BASE + 25'h00100, 8'h00);
    wait_req("stale_req1");
    rom_a = 19'h00200;
    push_req(1'b0, ROM_BASE + 25'h00200, 8'h00);
    wait_ack("stale_ack1");
    @(negedge clk);
    check_eq("stale_rom_do_kept", 32'(rom_do), 32'h77);
    wait_idle("stale_idle");
    check_eq("stale_req_cnt", 32'(req_cnt - base), 32'd2);
    check_eq("stale_rom_do", 32'(rom_do), 32'h22);
    rom_read = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of a write that is never acknowledged
    hold_ack       = 1'b1;
    cartram_addr   = 18'h00030;
    cartram_wrdata = 8'h99;
    cartram_wr     = 1'b1;
    rom_a          = 19'h00400;
    rom_read       = 1'b1;
    push_req(1'b1, RAM_BASE + 25'h00030, 8'h99);
    repeat (2) @(negedge clk);
    check_eq("mid_busy", 32'(busy), 32'd1);
    check_eq("mid_we", 32'(mem.mem_we), 32'd1);
    reset_n    = 1'b0;
    cartram_wr = 1'b0;
    rom_read   = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_req", 32'(mem.mem_req), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_rom_do", 32'(rom_do), 32'd0);
    reset_n  = 1'b1;
    hold_ack = 1'b0;
    base = req_cnt;
    repeat (20) @(negedge clk);
    check_eq("mid_no_pending", 32'(req_cnt - base), 32'd0);
    check_eq("mid_busy_after", 32'(busy), 32'd0);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
